// File: rtl/vedic_seq_mul8_if.sv
// Handshake and operand/result bundle for the sequential 8x8 Vedic multiplier.
interface vedic_seq_mul8_if;
    logic        start;
    logic [7:0]  a;
    logic [7:0]  b;
    logic        busy;
    logic        done;
    logic [15:0] product;

    modport master (output start, output a, output b,
                    input busy, input done, input product);
    modport slave  (input start, input a, input b,
                    output busy, output done, output product);
endinterface

// File: rtl/vedic_seq_mul8.sv
// Sequential 8x8 unsigned multiplier built on one 2x2 Vedic (Urdhva) core.
// Sixteen digit-pair partial products are accumulated, one per clock.

// 2x2 Urdhva-Tiryagbhyam multiplier core.
module vedic_2_x_2_mul (
    input  logic [1:0] a,
    input  logic [1:0] b,
    output logic [3:0] p
);
    logic cross0;
    logic cross1;
    logic carry;

    // Vertical and crosswise products combined with half adders
    always_comb begin
        cross0 = a[1] & b[0];
        cross1 = a[0] & b[1];
        carry  = cross0 & cross1;
        p[0]   = a[0] & b[0];
        p[1]   = cross0 ^ cross1;
        p[2]   = (a[1] & b[1]) ^ carry;
        p[3]   = (a[1] & b[1]) & carry;
    end
endmodule

module vedic_seq_mul8 (
    input  logic               clk,
    input  logic               rst_n,
    vedic_seq_mul8_if.slave    bus
);
    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t      state_q, state_d;
    logic [7:0]  a_q, a_d;
    logic [7:0]  b_q, b_d;
    logic [15:0] acc_q, acc_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [15:0] product_q, product_d;

    logic [1:0]  dig_i;
    logic [1:0]  dig_j;
    logic [1:0]  a_dig;
    logic [1:0]  b_dig;
    logic [3:0]  pp;
    logic [3:0]  shamt;
    logic [15:0] acc_sum;

    vedic_2_x_2_mul u_core (
        .a (a_dig),
        .b (b_dig),
        .p (pp)
    );

    // Digit selection and the weighted partial-product accumulation for the current step
    always_comb begin
        dig_i   = cnt_q[1:0];
        dig_j   = cnt_q[3:2];
        a_dig   = a_q[{dig_i, 1'b0} +: 2];
        b_dig   = b_q[{dig_j, 1'b0} +: 2];
        shamt   = {({1'b0, dig_i} + {1'b0, dig_j}), 1'b0};
        acc_sum = acc_q + ({12'h000, pp} << shamt);
    end

    // State and datapath registers with asynchronous active-low clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            a_q       <= '0;
            b_q       <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
            product_q <= '0;
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            b_q       <= b_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            product_q <= product_d;
        end
    end

    // Next-state logic: start only honoured from IDLE, sixteen steps in CALC
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.start) state_d = CALC;
            CALC:    if (cnt_q == 4'd15) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath next values: latch operands, step accumulator, publish product on the last step
    always_comb begin
        a_d       = a_q;
        b_d       = b_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        product_d = product_q;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    a_d   = bus.a;
                    b_d   = bus.b;
                    acc_d = '0;
                    cnt_d = '0;
                end
            end
            CALC: begin
                acc_d = acc_sum;
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == 4'd15) product_d = acc_sum;
            end
            default: ;
        endcase
    end

    // Outputs decoded from state; done is exactly the single DONE cycle
    always_comb begin
        bus.busy    = (state_q != IDLE);
        bus.done    = (state_q == DONE);
        bus.product = product_q;
    end
endmodule

// File: tb/tb_vedic_seq_mul8.sv
// Directed and randomised self-checking bench for vedic_seq_mul8.
module tb_vedic_seq_mul8;
    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    vedic_seq_mul8_if intf ();

    vedic_seq_mul8 dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (intf.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  a;
        logic [7:0]  b;
        logic [15:0] exp;
    } vec_t;

    vec_t vecs [12];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // One full operation; glitch>0 re-asserts start with FF*FF at that step to prove it is ignored
    task automatic do_op(input logic [7:0] av, input logic [7:0] bv,
                         input logic [15:0] exp, input int glitch, input string nm);
        int lat;
        int busy_n;
        logic [15:0] prev;
        bit held;
        @(negedge clk);
        intf.start = 1'b1;
        intf.a     = av;
        intf.b     = bv;
        prev       = intf.product;
        @(posedge clk);
        #1;
        intf.start = 1'b0;
        intf.a     = 8'($urandom);
        intf.b     = 8'($urandom);
        busy_n = intf.busy ? 1 : 0;
        held   = 1'b1;
        lat    = -1;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk);
            #1;
            if (k == glitch) begin
                intf.start = 1'b1;
                intf.a     = 8'hFF;
                intf.b     = 8'hFF;
            end else if (k == glitch + 1) begin
                intf.start = 1'b0;
            end
            if (intf.busy) busy_n++;
            if (intf.done) begin
                lat = k;
                break;
            end
            if (intf.product !== prev) held = 1'b0;
        end
        intf.start = 1'b0;
        check({nm, "_latency"}, 32'(lat), 32'd16);
        check({nm, "_product"}, {16'h0, intf.product}, {16'h0, exp});
        check({nm, "_held"}, {31'h0, held}, 32'd1);
        @(posedge clk);
        #1;
        check({nm, "_done_once"}, {31'h0, intf.done}, 32'd0);
        check({nm, "_idle"}, {31'h0, intf.busy}, 32'd0);
        check({nm, "_busy_cycles"}, 32'(busy_n), 32'd17);
    endtask

    initial begin
        bit no_done;
        logic [7:0] ra;
        logic [7:0] rb;
        checks   = 0;
        failures = 0;

        vecs[0]  = '{8'hFF, 8'hFF, 16'hFE01};
        vecs[1]  = '{8'hA5, 8'h5A, 16'h3A02};
        vecs[2]  = '{8'h00, 8'h37, 16'h0000};
        vecs[3]  = '{8'h37, 8'h00, 16'h0000};
        vecs[4]  = '{8'h01, 8'h01, 16'h0001};
        vecs[5]  = '{8'h10, 8'h10, 16'h0100};
        vecs[6]  = '{8'h80, 8'h02, 16'h0100};
        vecs[7]  = '{8'h0F, 8'h0F, 16'h00E1};
        vecs[8]  = '{8'h12, 8'h34, 16'h03A8};
        vecs[9]  = '{8'hFF, 8'h01, 16'h00FF};
        vecs[10] = '{8'hAA, 8'h55, 16'h3872};
        vecs[11] = '{8'h03, 8'h02, 16'h0006};

        rst_n      = 1'b0;
        intf.start = 1'b0;
        intf.a     = '0;
        intf.b     = '0;
        #1;
        check("reset_busy", {31'h0, intf.busy}, 32'd0);
        check("reset_done", {31'h0, intf.done}, 32'd0);
        check("reset_product", {16'h0, intf.product}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 12; i++)
            do_op(vecs[i].a, vecs[i].b, vecs[i].exp, -1, $sformatf("vec%0d", i));

        // start pulsed mid-operation must be ignored
        do_op(8'h03, 8'h02, 16'h0006, 5, "ignore_start");

        // reset at step 8 aborts with no trailing done pulse
        @(negedge clk);
        intf.start = 1'b1;
        intf.a     = 8'hFF;
        intf.b     = 8'hFF;
        @(posedge clk);
        #1;
        intf.start = 1'b0;
        repeat (8) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("abort_busy", {31'h0, intf.busy}, 32'd0);
        check("abort_done", {31'h0, intf.done}, 32'd0);
        check("abort_product", {16'h0, intf.product}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        no_done = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk);
            #1;
            if (intf.done || intf.busy) no_done = 1'b0;
        end
        check("abort_no_done", {31'h0, no_done}, 32'd1);
        do_op(8'h02, 8'h03, 16'h0006, -1, "after_abort");

        // back-to-back issue on the first IDLE cycle
        do_op(8'h10, 8'h10, 16'h0100, -1, "b2b_first");
        do_op(8'h80, 8'h02, 16'h0100, -1, "b2b_second");

        // randomised operands against a*b
        for (int n = 0; n < 1000; n++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            do_op(ra, rb, 16'(ra * rb), -1, "rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/vedic_seq_mul8.md
VEDIC_SEQ_MUL8 -- requirements
Module: vedic_seq_mul8

Interface
REQ-001 The block SHALL have no parameters; operand width is fixed at 8 bits and product width at 16 bits.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 start  input  1  request a multiply; sampled only when busy=0.
REQ-005 a  input  8  unsigned multiplicand; sampled with start.
REQ-006 b  input  8  unsigned multiplier; sampled with start.
REQ-007 busy  output  1  high while a multiply is in progress or completing.
REQ-008 done  output  1  one-cycle pulse when product is updated.
REQ-009 product  output  16  unsigned a*b of the last completed operation; held until the next completion.

Function
REQ-010 The block SHALL compute a*b iteratively with exactly one instance of vedic_2_x_2_mul, fed one 2-bit digit of each operand per cycle.
REQ-011 The block SHALL implement states IDLE, CALC, and DONE; busy SHALL equal (state != IDLE).
REQ-012 In IDLE with start=1 at edge E0, the block SHALL latch a and b into internal registers, clear the accumulator and the 4-bit step counter, and enter CALC.
REQ-013 In IDLE with start=0, the block SHALL remain in IDLE with all registers unchanged.
REQ-014 In CALC, each edge SHALL perform one step: i=cnt[1:0] selects a_reg[2i+1:2i], j=cnt[3:2] selects b_reg[2j+1:2j], and acc <= acc + (pp << 2*(i+j)), where pp is the 4-bit core output.
REQ-015 Steps SHALL occur at edges E1..E16, cnt SHALL run 0..15, and the counter SHALL increment by 1 per step.
REQ-016 The accumulator SHALL be 16 bits wide, and no overflow SHALL occur (max 255*255 = 65025).
REQ-017 At edge E16 (step cnt=15), the block SHALL load product with the final sum including that step, set done=1, and enter DONE.
REQ-018 At edge E17, the block SHALL clear done and return to IDLE; done SHALL be high for exactly one cycle.
REQ-019 Latency SHALL be fixed: done is high in the cycle following E16, independent of operand values, including zero operands.
REQ-020 start SHALL be ignored while busy=1 (CALC or DONE); operands SHALL NOT be re-sampled mid-operation.
REQ-021 Changes on a and b after E0 SHALL NOT affect the result of the operation in progress.
REQ-022 A start asserted in the cycle after E17 (first IDLE cycle) SHALL be accepted, giving a minimum issue interval of 18 cycles.
REQ-023 product SHALL change only at a completion edge (E16) or at reset.

Reset
REQ-024 While rst_n=0, the block SHALL immediately force state=IDLE, busy=0, done=0, product=16'h0000, acc=0, cnt=0, a_reg=0, and b_reg=0, without waiting for clk.
REQ-025 Reset asserted during CALC or DONE SHALL abort the operation, and no done pulse SHALL follow.
REQ-026 After rst_n deasserts, the first start SHALL be honoured at the first rising edge on which it is sampled high.

Verification
REQ-027 Scenario 1: reset, then start with a=8'hFF, b=8'hFF -> busy=1 for 17 cycles; done pulses once, 16 cycles after the start edge; product=16'hFE01.
REQ-028 Scenario 2: a=8'hA5, b=8'h5A -> product=16'h3A02; a=8'h00, b=8'h37 -> product=16'h0000, with the same 16-cycle latency.
REQ-029 Scenario 3: start with a=8'h03, b=8'h02, then pulse start with a=8'hFF, b=8'hFF at step 5 -> product=16'h0006; the second request is ignored and only one done pulse occurs.
REQ-030 Scenario 4: drop rst_n at step 8 of a=8'hFF*8'hFF -> busy, done, and product go to 0 immediately; no done pulse follows; a new start with a=8'h02, b=8'h03 yields 16'h0006.
REQ-031 Scenario 5: issue back-to-back starts on the first IDLE cycle after each done (a=8'h10*b=8'h10, then a=8'h80*b=8'h02) -> product=16'h0100, then 16'h0100; the issue interval is 18 cycles.
REQ-032 Scenario 6: randomised a and b over at least 1000 operations against a reference model -> every product matches a*b, and product holds steady between done pulses.
